// File: rtl/nec_decoder.sv
// NEC IR frame decoder: consumes (pulse, cnt) segments from ir_rx and reports
// address/command frames, repeat codes, and aborted frames with a reason code.
module nec_decoder #(
   parameter longint CLK_FREQ    = 50_000_000,
   parameter int     TOL_PCT     = 25,
   parameter int     TIMEOUT_CYC = 600_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_edge,
   input  logic        pulse,
   input  logic [24:0] cnt,
   output logic        valid,
   output logic        rpt,
   output logic [15:0] addr,
   output logic [7:0]  cmd,
   output logic        err,
   output logic [1:0]  err_code
);

   localparam logic [63:0] LEAD_NOM = 64'(CLK_FREQ) * 64'd9 / 64'd1000;
   localparam logic [63:0] HDR_NOM  = 64'(CLK_FREQ) * 64'd9 / 64'd2000;
   localparam logic [63:0] RPT_NOM  = 64'(CLK_FREQ) * 64'd9 / 64'd4000;
   localparam logic [63:0] BIT_NOM  = 64'(CLK_FREQ) * 64'd9 / 64'd16000;
   localparam logic [63:0] ONE_NOM  = 64'(CLK_FREQ) * 64'd27 / 64'd16000;
   localparam logic [63:0] PCT_LO   = 64'(100 - TOL_PCT);
   localparam logic [63:0] PCT_HI   = 64'(100 + TOL_PCT);

   localparam logic [63:0] LEAD_LO = LEAD_NOM * PCT_LO / 64'd100;
   localparam logic [63:0] LEAD_HI = LEAD_NOM * PCT_HI / 64'd100;
   localparam logic [63:0] HDR_LO  = HDR_NOM * PCT_LO / 64'd100;
   localparam logic [63:0] HDR_HI  = HDR_NOM * PCT_HI / 64'd100;
   localparam logic [63:0] RPT_LO  = RPT_NOM * PCT_LO / 64'd100;
   localparam logic [63:0] RPT_HI  = RPT_NOM * PCT_HI / 64'd100;
   localparam logic [63:0] BIT_LO  = BIT_NOM * PCT_LO / 64'd100;
   localparam logic [63:0] BIT_HI  = BIT_NOM * PCT_HI / 64'd100;
   localparam logic [63:0] ONE_LO  = ONE_NOM * PCT_LO / 64'd100;
   localparam logic [63:0] ONE_HI  = ONE_NOM * PCT_HI / 64'd100;

   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {IDLE, LEAD, D_MARK, D_SPACE, R_MARK} state_t;

   state_t      state, state_nx;
   logic [31:0] shift, shift_nx;
   logic [5:0]  bit_cnt, bit_cnt_nx;
   logic [31:0] idle_cnt, idle_cnt_nx;
   logic        have_frame;
   logic        emit_frame, emit_rpt, emit_err;
   logic [1:0]  code_nx;

   function automatic logic in_win(input logic [24:0] c, input logic [63:0] lo,
                                   input logic [63:0] hi);
      return (64'(c) >= lo) && (64'(c) <= hi);
   endfunction

   logic is_lead, is_hdr, is_rpt, is_bit, is_zero, is_one;
   assign is_lead = pulse  && in_win(cnt, LEAD_LO, LEAD_HI);
   assign is_hdr  = !pulse && in_win(cnt, HDR_LO, HDR_HI);
   assign is_rpt  = !pulse && in_win(cnt, RPT_LO, RPT_HI);
   assign is_bit  = pulse  && in_win(cnt, BIT_LO, BIT_HI);
   assign is_zero = !pulse && in_win(cnt, BIT_LO, BIT_HI);
   assign is_one  = !pulse && in_win(cnt, ONE_LO, ONE_HI);

   // Next-state and result decode; an edge always takes priority over the timeout.
   always_comb begin
      state_nx    = state;
      shift_nx    = shift;
      bit_cnt_nx  = bit_cnt;
      idle_cnt_nx = 32'd0;
      emit_frame  = 1'b0;
      emit_rpt    = 1'b0;
      emit_err    = 1'b0;
      code_nx     = 2'd1;
      if (rx_edge) begin
         case (state)
            IDLE: begin
               if (is_lead) state_nx = LEAD;
            end
            LEAD: begin
               if (is_hdr) begin
                  state_nx   = D_MARK;
                  bit_cnt_nx = 6'd0;
                  shift_nx   = 32'd0;
               end else if (is_rpt) begin
                  state_nx = R_MARK;
               end else begin
                  emit_err = 1'b1;
               end
            end
            D_MARK: begin
               if (!is_bit) begin
                  emit_err = 1'b1;
               end else if (bit_cnt == 6'd32) begin
                  state_nx = IDLE;
                  if (shift[31:24] == ~shift[23:16]) begin
                     emit_frame = 1'b1;
                  end else begin
                     emit_err = 1'b1;
                     code_nx  = 2'd2;
                  end
               end else begin
                  state_nx = D_SPACE;
               end
            end
            D_SPACE: begin
               if (is_zero || is_one) begin
                  shift_nx   = {is_one, shift[31:1]};
                  bit_cnt_nx = bit_cnt + 6'd1;
                  state_nx   = D_MARK;
               end else begin
                  emit_err = 1'b1;
               end
            end
            R_MARK: begin
               state_nx = IDLE;
               if (!is_bit) begin
                  emit_err = 1'b1;
               end else if (have_frame) begin
                  emit_rpt = 1'b1;
               end else begin
                  emit_err = 1'b1;
                  code_nx  = 2'd2;
               end
            end
            default: state_nx = IDLE;
         endcase
         // A lead mark that breaks a frame is itself the start of the next one.
         if (emit_err) state_nx = is_lead ? LEAD : IDLE;
      end else if (state != IDLE) begin
         if (idle_cnt == TIMEOUT_LAST) begin
            emit_err = 1'b1;
            code_nx  = 2'd3;
            state_nx = IDLE;
         end else begin
            idle_cnt_nx = idle_cnt + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         shift      <= 32'd0;
         bit_cnt    <= 6'd0;
         idle_cnt   <= 32'd0;
         have_frame <= 1'b0;
         valid      <= 1'b0;
         err        <= 1'b0;
         rpt        <= 1'b0;
         addr       <= 16'd0;
         cmd        <= 8'd0;
         err_code   <= 2'd0;
      end else begin
         state    <= state_nx;
         shift    <= shift_nx;
         bit_cnt  <= bit_cnt_nx;
         idle_cnt <= idle_cnt_nx;
         valid    <= emit_frame || emit_rpt;
         err      <= emit_err;
         if (emit_frame) begin
            addr       <= shift[15:0];
            cmd        <= shift[23:16];
            rpt        <= 1'b0;
            have_frame <= 1'b1;
         end
         if (emit_rpt) rpt <= 1'b1;
         if (emit_err) err_code <= code_nx;
      end
   end

endmodule
